// File: rtl/mem_copy_dma_pkg.sv
// Shared bus command encodings and fixed I/O addresses for CPU, DMA and top level.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_copy_dma_pkg;

    // Bus command encodings driven on mem_cmd
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // Memory-mapped I/O ports (bit 8 of the address selects I/O space)
    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    // True when an address falls in I/O space
    function automatic logic is_io(input logic [8:0] addr);
        return addr[8];
    endfunction

endpackage

// File: rtl/mem_copy_dma_rle.sv
// Load-enable holding register with asynchronous active-low clear.
// Latency: q_o updates one clock after en_i=1.
// Backpressure: none; holds its value while en_i=0.
module mem_copy_dma_rle #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Capture d_i only on enabled cycles; clear on reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_copy_dma.sv
// Bus initiator copying len 16-bit words from src_addr to dst_addr, ascending, one word at a time.
// Latency: 1 request cycle + 3 cycles per word + 1 finish cycle with a continuous grant; len=0 finishes next cycle.
// Backpressure: waits in REQ while bus_grant=0; grant is re-checked only between words.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD_A = 3'd2,
        S_RD_D = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] sa_q;
    logic [ADDR_W-1:0] da_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              bus_req_q;
    logic              busy_q;
    logic              done_q;

    logic              buf_en;
    logic [DATA_W-1:0] buf_dat;

    // Read data is valid during RD_D (RAM answers one clock after the address)
    assign buf_en = (state_q == S_RD_D);

    mem_copy_dma_rle #(
        .W (DATA_W)
    ) u_buf (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .en_i     (buf_en),
        .d_i      (read_data),
        .q_o      (buf_dat)
    );

    // Transfer sequencer: operand latching, word loop, grant handling and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            sa_q      <= '0;
            da_q      <= '0;
            cnt_q     <= '0;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sa_q  <= src_addr;
                        da_q  <= dst_addr;
                        cnt_q <= len;
                        if (len == '0) begin
                            // Empty copy: skip the bus entirely and just signal completion
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            busy_q    <= 1'b1;
                            bus_req_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_grant) begin
                        state_q <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    state_q <= S_RD_D;
                end
                S_RD_D: begin
                    state_q <= S_WR;
                end
                S_WR: begin
                    sa_q  <= sa_q + ADDR_W'(1);
                    da_q  <= da_q + ADDR_W'(1);
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_q   <= S_FIN;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        bus_req_q <= 1'b0;
                    end else if (bus_grant) begin
                        state_q <= S_RD_A;
                    end else begin
                        // Lost the bus between words: keep requesting and wait for it back
                        state_q <= S_REQ;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bus drive decoded from state; all-zero outside the word cycles so the top-level mux stays clean
    always_comb begin
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        unique case (state_q)
            S_RD_A, S_RD_D: begin
                mem_cmd  = MREAD;
                mem_addr = sa_q;
            end
            S_WR: begin
                mem_cmd    = MWRITE;
                mem_addr   = da_q;
                write_data = buf_dat;
            end
            default: begin
                mem_cmd    = MNONE;
            end
        endcase
    end

    assign bus_req = bus_req_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboarded bench for mem_copy_dma with a 1-cycle registered RAM, a switch port and an LED port.
// Latency: n/a.
// Backpressure: bus_grant driven tied-high, randomly toggled between words, or scripted.
module tb_mem_copy_dma;
    import mem_copy_dma_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          bus_grant = 1'b0;
    logic          bus_req;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          busy;
    logic          done;

    mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .bus_req    (bus_req),
        .bus_grant  (bus_grant),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // ---------------- bench memory system ----------------
    logic [DW-1:0] ram [512];
    logic [DW-1:0] mdl [512];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] led;
    logic [DW-1:0] sw_val = 16'h005A;
    logic [31:0]   seed = 32'h0;
    logic          load = 1'b0;
    logic          pk_we = 1'b0;
    logic [AW-1:0] pk_addr = '0;
    logic [DW-1:0] pk_dat = '0;

    function automatic logic [DW-1:0] init_pat(input int i, input logic [31:0] s);
        logic [31:0] v;
        v = (i * 40503 + 12345) ^ s ^ (i << 7);
        return v[DW-1:0];
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_pat(i, seed);
            led  <= '0;
            rd_q <= '0;
        end else begin
            if (pk_we) ram[pk_addr] <= pk_dat;
            else if (mem_cmd == MWRITE) begin
                ram[mem_addr] <= write_data;
                if (mem_addr == LED_ADDR) led <= write_data;
            end
            if (mem_cmd == MREAD) rd_q <= (mem_addr == SW_ADDR) ? sw_val : ram[mem_addr];
        end
    end
    assign read_data = rd_q;

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, required nothing (cycle %0d)", nm, act, cyc);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    typedef struct {
        int s;
        int lat;
        bit busy_before;
    } done_t;

    logic [AW-1:0] exp_rd [$];
    wr_t           exp_wr [$];
    done_t         exp_done [$];

    bit            prev_busy = 1'b0;
    int            rd_phase = 0;
    logic [AW-1:0] rd_last = '0;

    // Monitor: sample 1 time unit after each rising edge, pop and compare on every bus/done event
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!reset_n) begin
            rd_phase  = 0;
            prev_busy = 1'b0;
        end else begin
            if (mem_cmd == MNONE) begin
                check("idle_bus_clean", {7'd0, mem_addr, write_data}, 32'd0);
            end else if (mem_cmd == MREAD) begin
                if (rd_phase == 0) begin
                    if (exp_rd.size() == 0) fail_now("read_unexpected", 32'(mem_addr));
                    else check("read_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
                    rd_last  = mem_addr;
                    rd_phase = 1;
                end else begin
                    check("read_addr_held", 32'(mem_addr), 32'(rd_last));
                    rd_phase = 0;
                end
            end else if (mem_cmd == MWRITE) begin
                if (exp_wr.size() == 0) fail_now("write_unexpected", {7'd0, mem_addr, write_data});
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(w.a));
                    check("write_data", 32'(write_data), 32'(w.d));
                end
            end else begin
                fail_now("bad_mem_cmd", 32'(mem_cmd));
            end
            if (done) begin
                if (exp_done.size() == 0) fail_now("done_unexpected", 32'(cyc));
                else begin
                    done_t e;
                    e = exp_done.pop_front();
                    if (e.lat >= 0) check("done_latency", 32'(cyc - e.s + 1), 32'(e.lat));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("busy_before_done", 32'(prev_busy), 32'(e.busy_before));
                end
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    // Reference: ascending word-by-word copy on a flat 512-word map; the switch answers reads at SW_ADDR.
    // abort=1 models a reset during word 2's data phase: word 1 lands, word 2 is only addressed.
    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                         input bit timed, input bit abort);
        done_t e;
        int    nw;
        nw = abort ? 1 : n;
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ra, wa;
            ra = s + AW'(i);
            wa = d + AW'(i);
            if (i < nw) begin
                wr_t w;
                exp_rd.push_back(ra);
                w.a = wa;
                w.d = (ra == SW_ADDR) ? sw_val : mdl[ra];
                exp_wr.push_back(w);
                mdl[wa] = w.d;
            end else if (abort && i == 1) begin
                exp_rd.push_back(ra);
            end
        end
        if (!abort) begin
            e.s = cyc + 1;
            e.lat = timed ? ((n == 0) ? 1 : 3 * n + 2) : -1;
            e.busy_before = (n != 0);
            exp_done.push_back(e);
        end
        src_addr = s;
        dst_addr = d;
        len      = LW'(n);
        start    = 1'b1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        pk_we = 1'b1; pk_addr = a; pk_dat = v;
        mdl[a] = v;
        @(negedge clk);
        pk_we = 1'b0;
    endtask

    task automatic wait_cmd(input logic [1:0] c, input string nm);
        int k;
        k = 0;
        while (mem_cmd !== c && k < 100) begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        if (k >= 100) fail_now(nm, 32'(mem_cmd));
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        if (k >= 3000) fail_now(nm, 32'(done));
    endtask

    // mode 0: grant tied high (latency checked); mode 1: grant toggled randomly between words
    task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input int mode);
        int nr, nw, k;
        bit saw_req, saw_cmd;
        nr = 0; nw = 0; saw_req = 0; saw_cmd = 0;
        @(negedge clk);
        bus_grant = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        issue(s, d, n, mode == 0, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy && (k == 3 || $urandom_range(0, 15) == 0)) begin
                start = 1'b1;
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                len = LW'($urandom_range(0, 9));
            end else begin
                start = 1'b0;
            end
            if (mem_cmd == MREAD) nr++;
            if (mem_cmd == MWRITE) nw++;
            if (mem_cmd != MNONE) saw_cmd = 1;
            if (bus_req) saw_req = 1;
            if (mode == 1 && mem_cmd != MREAD) bus_grant = ($urandom_range(0, 3) != 0);
        end while (done !== 1'b1 && k < 3000);
        start = 1'b0;
        if (k >= 3000) fail_now("done_timeout", 32'(k));
        check("write_cycles", 32'(nw), 32'(n));
        check("read_cycles", 32'(nr), 32'(2 * n));
        if (n == 0) begin
            check("len0_no_bus_req", 32'(saw_req), 32'd0);
            check("len0_no_cmd", 32'(saw_cmd), 32'd0);
        end
    endtask

    initial begin
        seed = $urandom;
        load = 1'b1;
        for (int i = 0; i < 512; i++) mdl[i] = init_pat(i, seed);
        repeat (3) @(negedge clk);
        load = 1'b0;
        check("reset_outputs", {22'd0, bus_req, mem_cmd, busy, done, 5'd0},
              32'd0);
        check("reset_bus", {7'd0, mem_addr, write_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: four-word copy with continuous grant
        poke(9'h010, 16'h00A1);
        poke(9'h011, 16'h00B2);
        poke(9'h012, 16'h00C3);
        poke(9'h013, 16'h00D4);
        run_xfer(9'h010, 9'h080, 4, 0);
        @(negedge clk);
        check("t1_ram80", 32'(ram[9'h080]), 32'h00A1);
        check("t1_ram81", 32'(ram[9'h081]), 32'h00B2);
        check("t1_ram82", 32'(ram[9'h082]), 32'h00C3);
        check("t1_ram83", 32'(ram[9'h083]), 32'h00D4);

        // 2: zero-length request
        run_xfer(9'h033, 9'h044, 0, 0);

        // 3: grant withheld, then dropped during word 2 of a 3-word copy
        @(negedge clk);
        bus_grant = 1'b0;
        issue(9'h050, 9'h0A0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("t3_no_read_before_grant", {30'd0, bus_req, mem_cmd == MNONE}, 32'd3);
        end
        bus_grant = 1'b1;
        wait_cmd(MREAD, "t3_word1_read_timeout");
        wait_cmd(MWRITE, "t3_word1_write_timeout");
        wait_cmd(MREAD, "t3_word2_read_timeout");
        bus_grant = 1'b0;
        wait_cmd(MWRITE, "t3_word2_write_timeout");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_req_hold", {29'd0, bus_req, mem_cmd}, {29'd0, 1'b1, MNONE});
        end
        bus_grant = 1'b1;
        wait_done("t3_done_timeout");

        // 4: switch to LED, single word
        sw_val = 16'h005A;
        run_xfer(SW_ADDR, LED_ADDR, 1, 0);
        @(negedge clk);
        check("t4_led", 32'(led), 32'h005A);

        // 5: source wraps past the top of the address space
        run_xfer(9'h1FE, 9'h020, 3, 0);

        // 6: reset during the data phase of word 2, then a normal transfer
        @(negedge clk);
        bus_grant = 1'b1;
        issue(9'h0C0, 9'h0E0, 4, 1'b0, 1'b1);
        wait_cmd(MREAD, "t6_word1_read_timeout");
        wait_cmd(MWRITE, "t6_word1_write_timeout");
        wait_cmd(MREAD, "t6_word2_read_timeout");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_abort_outputs", {27'd0, bus_req, mem_cmd, busy, done}, 32'd0);
        check("t6_abort_bus", {7'd0, mem_addr, write_data}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_done_in_reset", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_idle_after_reset", {29'd0, bus_req, busy, done}, 32'd0);
        run_xfer(9'h0C0, 9'h0F0, 5, 0);

        // Random transfers, including overlapping regions and I/O addresses
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] s, d;
            int n;
            s = AW'($urandom);
            d = ($urandom_range(0, 3) == 0) ? s + AW'($urandom_range(0, 4)) : AW'($urandom);
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            run_xfer(s, d, n, $urandom_range(0, 1));
        end

        repeat (3) @(negedge clk);
        check("leftover_reads", 32'(exp_rd.size()), 32'd0);
        check("leftover_writes", 32'(exp_wr.size()), 32'd0);
        check("leftover_done", 32'(exp_done.size()), 32'd0);
        for (int i = 0; i < 512; i++) check($sformatf("final_mem_%03h", i), 32'(ram[i]), 32'(mdl[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
